m31_inverter: RTL and testbench

- Sequential modular inverter over the Mersenne-31 field, p = 2^31-1 = 2147483647.
- Computes a^(p-2) mod p by left-to-right square-and-multiply, using one shared M31 modular multiply per cycle.
- Provides the field division path of the Monolith accelerator, the inverse operation of the M31 multiplier.
- Valid/ready handshake on input and output.

---
 rtl/m31_inverter_if.sv | 22 ++
 rtl/m31_inverter.sv | 122 ++++++++++++
 tb/tb_m31_inverter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/m31_inverter_if.sv
// Handshake bundle for the M31 inverter: operand in, inverse (or zero flag) out.
interface m31_inverter_if #(
  parameter int DATA_WIDTH = 31
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/m31_inverter.sv
// Sequential Mersenne-31 inverter: a^EXPONENT mod (2^31-1) by left-to-right
// square-and-multiply, sharing one single-cycle modular multiplier.
module m31_inverter #(
  parameter int              DATA_WIDTH = 31,
  parameter logic [30:0]     EXPONENT   = 31'h7FFFFFFD
) (
  input  logic            clk,
  input  logic            rst,
  m31_inverter_if.slave   bus
);

  localparam logic [DATA_WIDTH-1:0] P_MOD = '1;

  typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] base, base_n;
  logic [DATA_WIDTH-1:0] res, res_n;
  logic [4:0]            idx, idx_n;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_n;
  logic                  out_zero_q, out_zero_n;
  logic [DATA_WIDTH-1:0] canon;
  logic [DATA_WIDTH-1:0] mul_b;
  logic [DATA_WIDTH-1:0] prod;

  // Fold the 62-bit product twice using 2^31 == 1 (mod p); the second fold
  // can only reach p itself, which is mapped back to 0.
  function automatic logic [30:0] mulmod(input logic [30:0] x, input logic [30:0] y);
    logic [61:0] p62;
    logic [31:0] r1;
    logic [30:0] r2;
    p62 = {31'd0, x} * {31'd0, y};
    r1  = {1'b0, p62[30:0]} + {1'b0, p62[61:31]};
    r2  = r1[30:0] + {30'd0, r1[31]};
    return (r2 == P_MOD) ? '0 : r2;
  endfunction

  assign canon = (bus.in_data == P_MOD) ? '0 : bus.in_data;
  assign mul_b = (state == MUL) ? base : res;
  assign prod  = mulmod(res, mul_b);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      res        <= '0;
      idx        <= '0;
      out_data_q <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state      <= state_n;
      base       <= base_n;
      res        <= res_n;
      idx        <= idx_n;
      out_data_q <= out_data_n;
      out_zero_q <= out_zero_n;
    end
  end

  // Bit 30 of the exponent is consumed by loading res with a, so the walk
  // starts at bit 29 and each set bit adds one MUL after its SQ.
  always_comb begin
    state_n    = state;
    base_n     = base;
    res_n      = res;
    idx_n      = idx;
    out_data_n = out_data_q;
    out_zero_n = out_zero_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          base_n = canon;
          res_n  = canon;
          idx_n  = 5'd29;
          if (canon == '0) begin
            state_n    = DONE;
            out_data_n = '0;
            out_zero_n = 1'b1;
          end else begin
            state_n = SQ;
          end
        end
      end
      SQ: begin
        res_n = prod;
        if (EXPONENT[idx]) begin
          state_n = MUL;
        end else if (idx == 5'd0) begin
          state_n    = DONE;
          out_data_n = prod;
          out_zero_n = 1'b0;
        end else begin
          idx_n = idx - 5'd1;
        end
      end
      MUL: begin
        res_n = prod;
        if (idx == 5'd0) begin
          state_n    = DONE;
          out_data_n = prod;
          out_zero_n = 1'b0;
        end else begin
          idx_n   = idx - 5'd1;
          state_n = SQ;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n    = IDLE;
          out_zero_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_m31_inverter.sv
// Directed and randomized bench for m31_inverter against a plain-arithmetic
// modular exponentiation model.
module tb_m31_inverter;

  localparam logic [63:0] P = 64'd2147483647;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  m31_inverter_if #(.DATA_WIDTH(31)) bus ();

  m31_inverter #(
    .DATA_WIDTH(31),
    .EXPONENT  (31'h7FFFFFFD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a^(p-2) mod p, right-to-left binary exponentiation.
  function automatic logic [63:0] ref_inv(input logic [63:0] a);
    logic [63:0] b, r, e;
    r = 64'd1;
    b = a % P;
    e = P - 64'd2;
    while (e != 64'd0) begin
      if (e[0]) r = (r * b) % P;
      b = (b * b) % P;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present an operand and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [30:0] a);
    int n;
    bus.in_data  = a;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 31'($urandom);
  endtask

  // Edges after the accepting edge until out_valid is observed.
  task automatic waitValid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) checkOutput("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [30:0] a, input logic [63:0] exp_data,
                       input logic exp_zero, input int exp_lat, output logic [30:0] got);
    int lat;
    applyStimulus(a);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_data"}, 64'(bus.out_data), exp_data);
    checkOutput({tag, "_zero"}, 64'(bus.out_zero), 64'(exp_zero));
    got = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_valid_clear"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_zero_clear"}, 64'(bus.out_zero), 64'd0);
    checkOutput({tag, "_data_kept"}, 64'(bus.out_data), exp_data);
  endtask

  initial begin
    logic [30:0]  got;
    logic [30:0]  held;
    logic [30:0]  ops[8];
    logic [63:0]  expq[$];
    int unsigned  acc_prev;
    int           lat;

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 31'd2;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("reset_out_zero", 64'(bus.out_zero), 64'd0);

    // First edge after release accepts the operand held during reset.
    rst = 1'b0;
    tick();
    checkOutput("first_accept", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    waitValid(lat);
    checkOutput("two_latency", 64'(lat), 64'd59);
    checkOutput("two_data", 64'(bus.out_data), 64'd1073741824);
    checkOutput("two_zero", 64'(bus.out_zero), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    runOp("one", 31'd1, 64'd1, 1'b0, 59, got);
    runOp("three", 31'd3, 64'd1431655765, 1'b0, 59, got);
    runOp("pm1", 31'd2147483646, 64'd2147483646, 1'b0, 59, got);
    runOp("field", 31'd686829796, ref_inv(64'd686829796), 1'b0, 59, got);
    checkOutput("field_product", (64'd686829796 * 64'(got)) % P, 64'd1);

    // Zero and non-canonical zero respond on the accepting edge itself.
    runOp("zero", 31'd0, 64'd0, 1'b1, 0, got);
    runOp("p_value", 31'h7FFFFFFF, 64'd0, 1'b1, 0, got);

    // Backpressure with a second operand waiting.
    applyStimulus(31'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 31'd7;
    waitValid(lat);
    checkOutput("bp_latency", 64'(lat), 64'd59);
    held = bus.out_data;
    checkOutput("bp_data", 64'(held), 64'd1431655765);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp_valid_hold", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_data_hold", 64'(bus.out_data), 64'd1431655765);
      checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp_not_yet_accepted", 64'(bus.in_ready), 64'd1);
    checkOutput("bp_valid_drop", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("bp_second_accepted", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    waitValid(lat);
    checkOutput("bp2_latency", 64'(lat), 64'd59);
    checkOutput("bp2_data", 64'(bus.out_data), ref_inv(64'd7));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Back-to-back stream of random operands with the consumer always ready.
    for (int i = 0; i < 8; i++) ops[i] = 31'($urandom_range(1, 2147483646));
    bus.out_ready = 1'b1;
    acc_prev = 0;
    for (int i = 0; i < 8; i++) begin
      int n;
      bus.in_data  = ops[i];
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      if (bus.in_ready !== 1'b1) checkOutput("stream_ready_timeout", 64'(bus.in_ready), 64'd1);
      tick();
      if (i > 0) checkOutput("stream_accept_gap", 64'(cyc - acc_prev), 64'd61);
      acc_prev = cyc;
      expq.push_back(ref_inv(64'(ops[i])));
      if (i == 7) bus.in_valid = 1'b0;
      waitValid(lat);
      checkOutput("stream_latency", 64'(lat), 64'd59);
      checkOutput("stream_data", 64'(bus.out_data), expq.pop_front());
      checkOutput("stream_product", (64'(ops[i]) * 64'(bus.out_data)) % P, 64'd1);
      tick();
    end
    bus.out_ready = 1'b0;
    tick();

    // Reset in the middle of an operation.
    applyStimulus(31'd5);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst = 1'b0;
    runOp("after_reset", 31'd5, 64'd858993459, 1'b0, 59, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
